feature_pingpong_bram: RTL and testbench

Double-buffered (ping-pong) feature-map buffer, the parametrised successor of the single-bank feature BRAM. It holds two banks of DEPTH x DATA_W words. The producer (conv/pool stage) fills one bank while the consumer (next layer) reads the other. Bank ownership swaps through a done/ready handshake, so layer N+1 reads frame k while layer N writes frame k+1.

---
 rtl/feature_pingpong_bram.sv | 130 +++++++++++++
 tb/tb_feature_pingpong_bram.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/feature_pingpong_bram.sv
// Double-buffered feature-map store: the producer fills one bank while the consumer drains
// the other, and ownership of each bank passes back and forth through done pulses.
module feature_pingpong_bram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              wr_ready,
  output logic              rd_ready,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam bit              RANGE_CHK = (DEPTH < (2**ADDR_W));

  logic [DATA_W-1:0] mem_r [0:1][0:DEPTH-1];

  logic [1:0]        full_r;
  logic [1:0]        full_nxt_s;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              err_r;

  logic              wr_ready_s;
  logic              rd_ready_s;
  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              wr_done_ok_s;
  logic              rd_done_ok_s;
  logic              viol_s;

  assign wr_ready_s   = ~full_r[wr_bank_r];
  assign rd_ready_s   = full_r[rd_bank_r];
  assign wr_ok_s      = wr_en & wr_ready_s & wr_in_range_s;
  assign rd_ok_s      = rd_en & rd_ready_s;
  assign wr_done_ok_s = wr_done & wr_ready_s;
  assign rd_done_ok_s = rd_done & rd_ready_s;

  // Address legality; a power-of-two depth makes every address legal
  always_comb begin
    wr_in_range_s = 1'b1;
    rd_in_range_s = 1'b1;
    if (RANGE_CHK) begin
      wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
      rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
    end else begin
      wr_in_range_s = 1'b1;
      rd_in_range_s = 1'b1;
    end
  end

  // Any request made without ownership, or to a non-existent word, is a protocol violation
  always_comb begin
    viol_s = (wr_en   & ~wr_ready_s)
           | (wr_en   & ~wr_in_range_s)
           | (wr_done & ~wr_ready_s)
           | (rd_en   & ~rd_ready_s)
           | (rd_en   & ~rd_in_range_s)
           | (rd_done & ~rd_ready_s);
  end

  // Per-bank full bits; a legal set and a legal clear can never target the same bank
  always_comb begin
    full_nxt_s = full_r;
    for (int b = 0; b < 2; b++) begin
      full_nxt_s[b] = (wr_done_ok_s & (wr_bank_r == 1'(b))) ? 1'b1 :
                      (rd_done_ok_s & (rd_bank_r == 1'(b))) ? 1'b0 : full_r[b];
    end
  end

  // Ownership pointers, read port register and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_r     <= 2'b00;
      wr_bank_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      full_r     <= full_nxt_s;
      rd_valid_r <= rd_ok_s;
      if (wr_done_ok_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
      if (rd_done_ok_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
      if (rd_ok_s) begin
        rd_data_r <= mem_r[rd_bank_r][rd_addr];
      end
      if (viol_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Bank storage, left unreset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_bank_r][wr_addr] <= wr_data;
    end
  end

  assign wr_ready = wr_ready_s;
  assign rd_ready = rd_ready_s;
  assign wr_bank  = wr_bank_r;
  assign rd_bank  = rd_bank_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign err      = err_r;

endmodule

// File: tb/tb_feature_pingpong_bram.sv
// Directed bench for feature_pingpong_bram: a default-size instance plus a
// non-power-of-two instance for the address range check.
module tb_feature_pingpong_bram;

  logic       clk;
  logic       reset;

  logic       wr_en, wr_done, rd_en, rd_done;
  logic [11:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic       wr_ready, rd_ready, wr_bank, rd_bank, rd_valid, err;
  logic [7:0] rd_data;

  logic       b_wr_en, b_wr_done, b_rd_en, b_rd_done;
  logic [6:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data;
  logic       b_wr_ready, b_rd_ready, b_wr_bank, b_rd_bank, b_rd_valid, b_err;
  logic [7:0] b_rd_data;

  int n_checks;
  int n_errors;

  feature_pingpong_bram #(.DATA_W(8), .DEPTH(4096), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .wr_ready(wr_ready), .rd_ready(rd_ready), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
  );

  feature_pingpong_bram #(.DATA_W(8), .DEPTH(100), .ADDR_W(7)) dut_b (
    .clk(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_done(b_wr_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_done(b_rd_done),
    .wr_ready(b_wr_ready), .rd_ready(b_rd_ready), .wr_bank(b_wr_bank), .rd_bank(b_rd_bank),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic write_word(input logic [11:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_wr_done();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b0;
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    wr_addr = 12'd0; rd_addr = 12'd0; wr_data = 8'd0;
    b_wr_en = 1'b0; b_wr_done = 1'b0; b_rd_en = 1'b0; b_rd_done = 1'b0;
    b_wr_addr = 7'd0; b_rd_addr = 7'd0; b_wr_data = 8'd0;
    #12;
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_rd_ready", 32'(rd_ready), 32'd0);
    check_eq("rst_wr_bank",  32'(wr_bank),  32'd0);
    check_eq("rst_rd_bank",  32'(rd_bank),  32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data",  32'(rd_data),  32'd0);
    check_eq("rst_err",      32'(err),      32'd0);
    reset = 1'b1;

    // read with no owned bank right after reset
    rd_en = 1'b1; rd_addr = 12'd0;
    tick();
    rd_en = 1'b0;
    check_eq("early_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("early_rd_data",  32'(rd_data),  32'd0);
    check_eq("early_err",      32'(err),      32'd1);
    pulse_reset();
    check_eq("err_cleared", 32'(err), 32'd0);

    // single frame into bank 0, then read it back
    for (int i = 0; i < 16; i++) write_word(12'(i), 8'(i));
    pulse_wr_done();
    check_eq("f1_wr_bank",  32'(wr_bank),  32'd1);
    check_eq("f1_rd_ready", 32'(rd_ready), 32'd1);
    check_eq("f1_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 12'(i);
      tick();
      check_eq("f1_rd_valid", 32'(rd_valid), 32'd1);
      check_eq("f1_rd_data",  32'(rd_data),  32'(i));
    end
    rd_en = 1'b0;
    tick();
    check_eq("f1_rd_idle", 32'(rd_valid), 32'd0);
    check_eq("f1_err",     32'(err),      32'd0);

    // both banks full, dropped write, then release one
    pulse_reset();
    write_word(12'd3, 8'h33);
    pulse_wr_done();
    write_word(12'd3, 8'h55);
    pulse_wr_done();
    check_eq("full_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("full_wr_bank",  32'(wr_bank),  32'd0);
    check_eq("full_err0",     32'(err),      32'd0);
    write_word(12'd3, 8'hAA);
    check_eq("full_drop_err", 32'(err), 32'd1);
    rd_en = 1'b1; rd_addr = 12'd3;
    tick();
    rd_en = 1'b0;
    check_eq("full_b0_data", 32'(rd_data), 32'h33);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check_eq("rel_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rel_wr_bank",  32'(wr_bank),  32'd0);
    check_eq("rel_rd_bank",  32'(rd_bank),  32'd1);
    rd_en = 1'b1; rd_addr = 12'd3;
    tick();
    rd_en = 1'b0;
    check_eq("rel_b1_data", 32'(rd_data), 32'h55);

    // steady ping-pong, done pulses coincide with the last write and read of a frame
    pulse_reset();
    for (int a = 0; a < 16; a++) write_word(12'(a), 8'(a));
    pulse_wr_done();
    for (int f = 1; f <= 4; f++) begin
      for (int a = 0; a < 16; a++) begin
        wr_en = 1'b1; wr_addr = 12'(a); wr_data = 8'(f * 16 + a);
        rd_en = 1'b1; rd_addr = 12'(a);
        wr_done = (a == 15); rd_done = (a == 15);
        tick();
        check_eq("pp_rd_valid", 32'(rd_valid), 32'd1);
        check_eq("pp_rd_data",  32'(rd_data),  32'((f - 1) * 16 + a));
      end
    end
    wr_en = 1'b0; wr_done = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 12'(a); rd_done = (a == 15);
      tick();
      check_eq("pp_last_data", 32'(rd_data), 32'(64 + a));
    end
    rd_en = 1'b0; rd_done = 1'b0;
    check_eq("pp_err",      32'(err),      32'd0);
    check_eq("pp_wr_bank",  32'(wr_bank),  32'd1);
    check_eq("pp_rd_bank",  32'(rd_bank),  32'd1);
    check_eq("pp_rd_ready", 32'(rd_ready), 32'd0);
    check_eq("pp_wr_ready", 32'(wr_ready), 32'd1);

    // reset while reading a full bank
    for (int a = 0; a < 4; a++) write_word(12'(a), 8'(8'hC0 + 8'(a)));
    pulse_wr_done();
    rd_en = 1'b1; rd_addr = 12'd0;
    tick();
    check_eq("mr_rd_data",  32'(rd_data),  32'hC0);
    check_eq("mr_rd_valid", 32'(rd_valid), 32'd1);
    rd_addr = 12'd1;
    reset = 1'b0;
    #1;
    check_eq("mr_rd_valid0", 32'(rd_valid), 32'd0);
    check_eq("mr_rd_ready",  32'(rd_ready), 32'd0);
    check_eq("mr_wr_ready",  32'(wr_ready), 32'd1);
    check_eq("mr_wr_bank",   32'(wr_bank),  32'd0);
    check_eq("mr_rd_bank",   32'(rd_bank),  32'd0);
    reset = 1'b1;
    rd_en = 1'b0;
    tick();
    check_eq("mr_after_valid", 32'(rd_valid), 32'd0);
    check_eq("mr_after_err",   32'(err),      32'd0);

    // non-power-of-two depth: out-of-range write must not touch the bank
    for (int a = 0; a < 100; a++) begin
      b_wr_en = 1'b1; b_wr_addr = 7'(a); b_wr_data = 8'(a) ^ 8'h5A;
      tick();
    end
    check_eq("oor_err0", 32'(b_err), 32'd0);
    b_wr_addr = 7'd120; b_wr_data = 8'hEE;
    tick();
    b_wr_en = 1'b0;
    check_eq("oor_err", 32'(b_err), 32'd1);
    b_wr_done = 1'b1;
    tick();
    b_wr_done = 1'b0;
    check_eq("oor_wr_bank",  32'(b_wr_bank),  32'd1);
    check_eq("oor_rd_bank",  32'(b_rd_bank),  32'd0);
    check_eq("oor_rd_ready", 32'(b_rd_ready), 32'd1);
    check_eq("oor_wr_ready", 32'(b_wr_ready), 32'd1);
    for (int a = 0; a < 100; a++) begin
      b_rd_en = 1'b1; b_rd_addr = 7'(a);
      tick();
      check_eq("oor_rd_valid", 32'(b_rd_valid), 32'd1);
      check_eq("oor_mem",      32'(b_rd_data),  32'(8'(a) ^ 8'h5A));
    end
    b_rd_en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
